i2s_transmitter: RTL and testbench
==================================

# i2s_transmitter

Serial I2S transmitter, the counterpart of the I2S receiver in the spectrometer datapath. It accepts stereo 24-bit sample pairs over a valid/ready handshake, generates WS, and shifts SD MSB-first in standard Philips I2S framing: 64 SCK per frame, 32-bit slots, and a one-bit delay after each WS edge. It drives test tones or loopback data into the receiver path and any external I2S DAC.

## Interface
Parameters:
- SAMPLE_WIDTH, 24: bits per channel word; must be ≤ SLOT_BITS−1.
- SLOT_BITS, 32: SCK cycles per channel slot; a frame is 2·SLOT_BITS.

Ports:
- i2s_clk  in  1  bit clock; the only clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  transmit enable; sampled at frame boundaries only.
- left_in  in  SAMPLE_WIDTH  left word, two's complement.
- right_in  in  SAMPLE_WIDTH  right word.
- in_valid  in  1  a sample pair is presented.
- in_ready  out  1  the holding buffer can accept a pair.
- SCK  out  1  passthrough of i2s_clk.
- WS  out  1  word select: 0 = left slot, 1 = right slot.
- SD  out  1  serial data.
- underrun  out  1  one-cycle pulse when a frame starts with no buffered pair.

## Operation
- State: bit counter bit_cnt (0..63), a holding buffer (left, right, full flag), a frame register (left, right), and a running flag.
- Handshake: in_ready = ~full, registered. A transfer happens when in_valid & in_ready: the buffer loads and full is set. in_valid may be held indefinitely. Data is ignored when in_ready = 0.
- Frame boundary is the cycle where bit_cnt = 63, or where running = 0.
  - If en = 1 and full = 1: the buffer moves to the frame register, full clears, running = 1.
  - If en = 1 and full = 0: the frame register is zeroed, underrun pulses, running = 1.
  - If en = 0: running = 0 and bit_cnt holds at 0.
- While running, bit_cnt increments each cycle and wraps from 63 to 0.
- Slot layout, for slot position p = bit_cnt mod 32 during the cycle bit_cnt holds that value:
  - WS = bit_cnt[5].
  - p = 0: SD = 0 (delay bit).
  - p = 1..24: SD = word[24−p], MSB first; word is left for bit_cnt < 32, right otherwise.
  - p = 25..31: SD = 0.
- When not running: WS = 0 and SD = 0.
- WS and SD are registered outputs, computed from the next-state counter, so they change only on rising edges of i2s_clk.

## Timing
- Reset (async assert, sync deassert internally) values: bit_cnt = 0, running = 0, full = 0, in_ready = 0 during reset and 1 on the first cycle after, WS = 0, SD = 0, underrun = 0, frame register = 0.
- Latency: a pair accepted before a boundary appears in the next frame. The left MSB is on SD at bit_cnt = 1 of that frame.
- Frame period: exactly 64 cycles, with no gaps while en stays 1.
- Boundary conditions:
  - Acceptance and drain never coincide, because ready = 0 while full. in_ready rises the cycle after the drain at bit_cnt = 63.
  - Dropping en mid-frame completes the current frame; transmission stops at the next boundary.
  - An underrun frame transmits zeros with normal WS timing.
  - reset_n asserted mid-frame: all state returns to reset values immediately, and any buffered pair is lost.

## Structure
- Shared package i2s_pkg holds I2S_SAMPLE_WIDTH = 24, I2S_SLOT_BITS = 32, and I2S_FRAME_BITS = 64. The receiver uses the same constants.
- Single module with no sub-module. The holding buffer is one register stage and does not justify a separate FIFO.

## Test plan
- Reset release, then left = 0xA5A5A5, right = 0x123456 pushed: frame 1 is all-zero with an underrun pulse. In frame 2, SD at bit_cnt 1..24 = 1010_0101 repeated; at 33..56 = 0x123456 MSB first; every other position = 0.
- Loopback to the i2s_receiver on the same clock: SAMPLE = 0xA5A5A5 with SAMPLE_VALID high one cycle after WS rises (bit_cnt = 33).
- Continuous in_valid with incrementing data: one pair accepted per 64 cycles, in_ready low for exactly 63 cycles, no underrun, and no gaps in WS.
- en deasserted at bit_cnt = 10: the frame completes, then WS = SD = 0 and bit_cnt holds. Re-asserting en restarts a frame with WS = 0 on the next cycle.
- Left = 0x800000, right = 0x7FFFFF: SD is 1 only at bit_cnt 1 in the left slot, and 1 at bit_cnt 34..56 in the right slot.
- reset_n pulsed at bit_cnt = 40 with the buffer full: WS = SD = 0 and in_ready = 0 asynchronously; after release the next frame is an underrun.

Source files
------------

// File: rtl/i2s_pkg.sv
// ============================================================================
// Module  : i2s_pkg
// Brief   : Shared I2S framing constants and transmitter state type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

    localparam int I2S_SAMPLE_WIDTH = 24;
    localparam int I2S_SLOT_BITS    = 32;
    localparam int I2S_FRAME_BITS   = 2 * I2S_SLOT_BITS;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_RUN  = 1'b1
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/i2s_transmitter_if.sv
// ============================================================================
// Module  : i2s_transmitter_if
// Brief   : Stereo sample-pair valid/ready bus feeding the I2S transmitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2s_transmitter_if
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH
);

    logic [SAMPLE_WIDTH-1:0] left_in;
    logic [SAMPLE_WIDTH-1:0] right_in;
    logic                    in_valid;
    logic                    in_ready;

    modport master (
        output left_in,
        output right_in,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  left_in,
        input  right_in,
        input  in_valid,
        output in_ready
    );

endinterface

`default_nettype wire

// File: rtl/i2s_transmitter.sv
// ============================================================================
// Module  : i2s_transmitter
// Brief   : Philips I2S serialiser, 64 SCK frames, one-pair holding buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int SLOT_BITS    = I2S_SLOT_BITS
) (
    input  logic             i2s_clk,
    input  logic             reset_n,
    input  logic             en,
    i2s_transmitter_if.slave tx,
    output logic             SCK,
    output logic             WS,
    output logic             SD,
    output logic             underrun
);

    localparam int                 c_frame_bits = 2 * SLOT_BITS;
    localparam int                 c_cnt_w      = $clog2(c_frame_bits);
    localparam logic [c_cnt_w-1:0] c_last       = c_cnt_w'(c_frame_bits - 1);
    localparam logic [c_cnt_w-1:0] c_slot       = c_cnt_w'(SLOT_BITS);
    localparam logic [c_cnt_w-1:0] c_sw         = c_cnt_w'(SAMPLE_WIDTH);
    localparam logic [c_cnt_w-1:0] c_one        = c_cnt_w'(1);

    logic [1:0]              r_rst_sync;
    logic                    w_rst_n;

    tx_state_t               r_state;
    logic [c_cnt_w-1:0]      r_bit_cnt;
    logic                    r_full;
    logic [SAMPLE_WIDTH-1:0] r_buf_l;
    logic [SAMPLE_WIDTH-1:0] r_buf_r;
    logic [SAMPLE_WIDTH-1:0] r_frm_l;
    logic [SAMPLE_WIDTH-1:0] r_frm_r;
    logic                    r_in_ready;
    logic                    r_ws;
    logic                    r_sd;
    logic                    r_underrun;

    logic                    w_boundary;
    logic                    w_take;
    tx_state_t               w_state_nx;
    logic [c_cnt_w-1:0]      w_bit_cnt_nx;
    logic                    w_full_nx;
    logic [SAMPLE_WIDTH-1:0] w_buf_l_nx;
    logic [SAMPLE_WIDTH-1:0] w_buf_r_nx;
    logic [SAMPLE_WIDTH-1:0] w_frm_l_nx;
    logic [SAMPLE_WIDTH-1:0] w_frm_r_nx;
    logic                    w_underrun_nx;

    logic                    w_right;
    logic [c_cnt_w-1:0]      w_pos;
    logic [c_cnt_w-1:0]      w_shift;
    logic [SAMPLE_WIDTH-1:0] w_word;
    logic                    w_ws_nx;
    logic                    w_sd_nx;

    // Reset asserts asynchronously but leaves on a clock edge.
    always_ff @(posedge i2s_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    always_comb begin
        w_boundary    = (r_state == TX_IDLE) || (r_bit_cnt == c_last);
        w_take        = tx.in_valid && r_in_ready;
        w_state_nx    = r_state;
        w_bit_cnt_nx  = r_bit_cnt + c_one;
        w_full_nx     = r_full;
        w_buf_l_nx    = r_buf_l;
        w_buf_r_nx    = r_buf_r;
        w_frm_l_nx    = r_frm_l;
        w_frm_r_nx    = r_frm_r;
        w_underrun_nx = 1'b0;

        // in_ready mirrors ~full, so a load never meets a drain.
        if (w_take) begin
            w_buf_l_nx = tx.left_in;
            w_buf_r_nx = tx.right_in;
            w_full_nx  = 1'b1;
        end

        if (w_boundary) begin
            w_bit_cnt_nx = '0;
            if (!en) begin
                w_state_nx = TX_IDLE;
            end else begin
                w_state_nx = TX_RUN;
                if (r_full) begin
                    w_frm_l_nx = r_buf_l;
                    w_frm_r_nx = r_buf_r;
                    w_full_nx  = 1'b0;
                end else begin
                    w_frm_l_nx    = '0;
                    w_frm_r_nx    = '0;
                    w_underrun_nx = 1'b1;
                end
            end
        end
    end

    // Outputs derive from next state so registered WS/SD line up with bit_cnt.
    always_comb begin
        w_right = (w_bit_cnt_nx >= c_slot);
        w_pos   = w_right ? (w_bit_cnt_nx - c_slot) : w_bit_cnt_nx;
        w_word  = w_right ? w_frm_r_nx : w_frm_l_nx;
        w_shift = c_sw - w_pos;
        w_ws_nx = (w_state_nx == TX_RUN) && w_right;
        w_sd_nx = (w_state_nx == TX_RUN) && (w_pos != '0) && (w_pos <= c_sw) &&
                  (|(w_word & (SAMPLE_WIDTH'(1) << w_shift)));
    end

    always_ff @(posedge i2s_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= TX_IDLE;
            r_bit_cnt  <= '0;
            r_full     <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
            r_frm_l    <= '0;
            r_frm_r    <= '0;
            r_in_ready <= 1'b0;
            r_ws       <= 1'b0;
            r_sd       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_full     <= w_full_nx;
            r_buf_l    <= w_buf_l_nx;
            r_buf_r    <= w_buf_r_nx;
            r_frm_l    <= w_frm_l_nx;
            r_frm_r    <= w_frm_r_nx;
            r_in_ready <= !w_full_nx;
            r_ws       <= w_ws_nx;
            r_sd       <= w_sd_nx;
            r_underrun <= w_underrun_nx;
        end
    end

    assign SCK         = i2s_clk;
    assign WS          = r_ws;
    assign SD          = r_sd;
    assign underrun    = r_underrun;
    assign tx.in_ready = r_in_ready;

endmodule

`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
// ============================================================================
// Module  : tb_i2s_transmitter
// Brief   : Self-checking bench for i2s_transmitter against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_transmitter;
    import i2s_pkg::*;

    localparam int SW    = I2S_SAMPLE_WIDTH;
    localparam int SLOT  = I2S_SLOT_BITS;
    localparam int FRAME = I2S_FRAME_BITS;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic en      = 1'b0;
    logic SCK, WS, SD, underrun;

    i2s_transmitter_if #(.SAMPLE_WIDTH(SW)) tx ();

    i2s_transmitter #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SLOT)) dut (
        .i2s_clk  (clk),
        .reset_n  (reset_n),
        .en       (en),
        .tx       (tx),
        .SCK      (SCK),
        .WS       (WS),
        .SD       (SD),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frame position (-1 = idle), pending pairs, current frame words.
    logic [2*SW-1:0] m_buf[$];
    logic [2*SW-1:0] m_frame;
    int              m_pos;
    bit              m_under;
    bit              m_live;

    typedef struct {
        logic [SW-1:0] left;
        logic [SW-1:0] right;
        logic [63:0]   frame;   // SD timeline, bit_cnt 0 in the MSB
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic exp_sd(input int pos, input logic [2*SW-1:0] frm);
        int            p;
        logic [SW-1:0] w;
        if (pos < 0) return 1'b0;
        p = pos % SLOT;
        w = (pos < SLOT) ? frm[2*SW-1:SW] : frm[SW-1:0];
        if (p >= 1 && p <= SW) return w[SW-p];
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_buf.delete();
        m_frame = '0;
        m_pos   = -1;
        m_under = 1'b0;
        m_live  = 1'b0;
    endtask

    task automatic model_edge(input bit en_v, input bit valid_v, input logic [2*SW-1:0] pair);
        bit accept;
        accept = valid_v && m_live && (m_buf.size() == 0);
        if (m_pos < 0 || m_pos == FRAME - 1) begin
            if (en_v) begin
                m_pos = 0;
                if (m_buf.size() > 0) begin
                    m_frame = m_buf.pop_front();
                    m_under = 1'b0;
                end else begin
                    m_frame = '0;
                    m_under = 1'b1;
                end
            end else begin
                m_pos   = -1;
                m_under = 1'b0;
            end
        end else begin
            m_pos++;
            m_under = 1'b0;
        end
        if (accept) m_buf.push_back(pair);
        m_live = 1'b1;
    endtask

    task automatic compare_all();
        check("ws", WS, m_pos >= SLOT);
        check("sd", SD, exp_sd(m_pos, m_frame));
        check("in_ready", tx.in_ready, m_live && (m_buf.size() == 0));
        check("underrun", underrun, m_under);
        check("sck", SCK, clk);
    endtask

    // One clock: inputs are already driven; compare on the falling edge.
    task automatic step();
        logic [2*SW-1:0] p;
        bit              e, v;
        p = {tx.left_in, tx.right_in};
        e = en;
        v = tx.in_valid;
        @(posedge clk);
        model_edge(e, v, p);
        @(negedge clk);
        compare_all();
    endtask

    task automatic release_and_align();
        bit got;
        got = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 6 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (tx.in_ready === 1'b1) begin
                got = 1'b1;
                model_edge(en, 1'b0, '0);
                compare_all();
            end else begin
                check("sync_ws", WS, 1'b0);
                check("sync_sd", SD, 1'b0);
                check("sync_underrun", underrun, 1'b0);
            end
        end
        if (!got) fail_bound("align_in_ready");
    endtask

    task automatic wait_pos(input int target, input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (m_pos != target && k < budget);
        if (m_pos != target) fail_bound("wait_pos");
    endtask

    task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
        bit done;
        done = 1'b0;
        tx.left_in  = l;
        tx.right_in = r;
        tx.in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            done = m_live && (m_buf.size() == 0);
            step();
        end
        tx.in_valid = 1'b0;
        if (!done) fail_bound("push_pair");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] cap;
        int          run, ws_hi;
        bit          seen;

        vecs[0] = '{left: 24'hA5A5A5, right: 24'h123456, frame: 64'h52D2D280_091A2B00};
        vecs[1] = '{left: 24'h800000, right: 24'h7FFFFF, frame: 64'h40000000_3FFFFF80};
        vecs[2] = '{left: 24'h000000, right: 24'h000000, frame: 64'h00000000_00000000};
        vecs[3] = '{left: 24'hFFFFFF, right: 24'h000001, frame: 64'h7FFFFF80_00000080};
        vecs[4] = '{left: 24'h000001, right: 24'hFFFFFF, frame: 64'h00000080_7FFFFF80};

        model_reset();
        tx.in_valid = 1'b0;
        tx.left_in  = '0;
        tx.right_in = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", tx.in_ready, 1'b0);
        check("rst_ws", WS, 1'b0);
        check("rst_sd", SD, 1'b0);
        check("rst_underrun", underrun, 1'b0);

        en = 1'b1;
        release_and_align();
        check("first_frame_underrun", underrun, 1'b1);

        // Fixed pairs, each captured as a whole 64-bit SD frame.
        for (int i = 0; i < 5; i++) begin
            push_pair(vecs[i].left, vecs[i].right);
            wait_pos(0, 200);
            cap     = '0;
            cap[63] = SD;
            for (int b = 1; b < FRAME; b++) begin
                step();
                cap[63-b] = SD;
            end
            check($sformatf("frame%0d", i), cap, vecs[i].frame);
        end

        // Continuous valid with incrementing data: one pair per frame.
        run  = 0;
        seen = 1'b0;
        tx.in_valid = 1'b1;
        for (int c = 0; c < 6 * FRAME; c++) begin
            tx.left_in  = SW'(c);
            tx.right_in = SW'(c + 1);
            step();
            if (!tx.in_ready) begin
                run++;
            end else begin
                if (run > 0) begin
                    if (seen) check("ready_low_run", run, 63);
                    seen = 1'b1;
                end
                run = 0;
            end
        end
        tx.in_valid = 1'b0;

        // Randomised traffic with occasional enable toggles.
        for (int c = 0; c < 2000; c++) begin
            tx.in_valid = ($urandom_range(0, 3) != 0);
            tx.left_in  = SW'($urandom);
            tx.right_in = SW'($urandom);
            if ($urandom_range(0, 299) == 0) en = ~en;
            step();
        end
        tx.in_valid = 1'b0;
        en          = 1'b1;

        // Drop enable mid-frame: the frame completes, then the line goes quiet.
        wait_pos(10, 200);
        en    = 1'b0;
        ws_hi = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (WS === 1'b1) ws_hi++;
        end
        check("ws_after_drop", ws_hi, 32);
        en = 1'b1;
        step();
        check("restart_ws", WS, 1'b0);
        repeat (70) step();

        // Reset mid-frame with the buffer full: the pair is lost.
        wait_pos(39, 200);
        push_pair(24'h5A5A5A, 24'h3C3C3C);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_ws", WS, 1'b0);
        check("async_rst_sd", SD, 1'b0);
        check("async_rst_in_ready", tx.in_ready, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("held_rst_in_ready", tx.in_ready, 1'b0);
        release_and_align();
        check("post_reset_underrun", underrun, 1'b1);
        repeat (2 * FRAME) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
